// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative execute-stage ALU.
package alu_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned OP_W     = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_AND  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  // Codes at or above this value are not defined operations
  localparam logic [OP_W-1:0] ALU_OP_ILLEGAL_MIN = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } exec_state_e;

  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Single-cycle arithmetic, compare and bitwise operations plus illegal-code detect.
module alu_logic_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result_c,
  output logic            illegal_c
);

  always_comb begin
    result_c  = '0;
    illegal_c = (op >= ALU_OP_ILLEGAL_MIN);
    case (op)
      ALU_ADD:  result_c = a + b;
      ALU_SUB:  result_c = a - b;
      ALU_SLT:  result_c = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: result_c = XLEN'(a < b);
      ALU_XOR:  result_c = a ^ b;
      ALU_OR:   result_c = a | b;
      ALU_AND:  result_c = a & b;
      // shifts are handled by the iterative datapath; illegal codes yield 0
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative shifts of SHIFT_STEP bits per cycle.
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [OP_W-1:0] i_alu_op,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);
  localparam int unsigned AMT_W   = $clog2(SHIFT_STEP) + 1;

  exec_state_e          state;
  exec_state_e          next_state;

  logic [OP_W-1:0]      op_q;
  logic [XLEN-1:0]      shift_q;
  logic [SHAMT_W-1:0]   cnt_q;

  logic [OP_W-1:0]      op_d;
  logic [XLEN-1:0]      shift_d;
  logic [SHAMT_W-1:0]   cnt_d;
  logic [XLEN-1:0]      result_d;
  logic                 illegal_d;
  logic                 valid_d;
  logic                 ready_d;

  logic [XLEN-1:0]      logic_result;
  logic                 logic_illegal;
  logic [SHAMT_W-1:0]   shamt;
  logic                 start_shift;
  logic [AMT_W-1:0]     amt;
  logic [SHAMT_W-1:0]   cnt_rem;
  logic [XLEN-1:0]      shifted;

  alu_logic_unit #(
    .XLEN (XLEN)
  ) u_logic (
    .op        (i_alu_op),
    .a         (i_operand_a),
    .b         (i_operand_b),
    .result_c  (logic_result),
    .illegal_c (logic_illegal)
  );

  assign shamt       = i_operand_b[SHAMT_W-1:0];
  assign start_shift = is_shift_op(i_alu_op) && (shamt != '0);

  // One shift step: the smaller of the remaining count and SHIFT_STEP
  assign amt     = (cnt_q < SHAMT_W'(SHIFT_STEP)) ? cnt_q[AMT_W-1:0] : AMT_W'(SHIFT_STEP);
  assign cnt_rem = cnt_q - SHAMT_W'(amt);

  always_comb begin
    shifted = '0;
    case (op_q)
      ALU_SLL: shifted = shift_q << amt;
      ALU_SRL: shifted = shift_q >> amt;
      default: shifted = XLEN'($signed(shift_q) >>> amt);
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    next_state = state;
    if (i_flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_valid) next_state = start_shift ? SHIFT : DONE;
        SHIFT:   if (cnt_rem == '0) next_state = DONE;
        DONE:    if (i_ready) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Next values for outputs and the shift datapath
  always_comb begin
    op_d      = op_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    result_d  = o_result;
    illegal_d = o_illegal;
    valid_d   = (next_state == DONE);
    ready_d   = (next_state == IDLE);
    if (!i_flush) begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            op_d    = i_alu_op;
            shift_d = i_operand_a;
            cnt_d   = shamt;
            // a shift by zero completes immediately with operand a
            if (is_shift_op(i_alu_op)) begin
              result_d  = i_operand_a;
              illegal_d = 1'b0;
            end else begin
              result_d  = logic_result;
              illegal_d = logic_illegal;
            end
          end
        end
        SHIFT: begin
          shift_d = shifted;
          cnt_d   = cnt_rem;
          if (cnt_rem == '0) result_d = shifted;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_ready   <= 1'b1;
      o_result  <= '0;
      o_illegal <= 1'b0;
      op_q      <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
    end else begin
      o_valid   <= valid_d;
      o_ready   <= ready_d;
      o_result  <= result_d;
      o_illegal <= illegal_d;
      op_q      <= op_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
